seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the 4-digit multiplexed 7-segment driver.
- Samples the scanned anode/cathode buses, waits for each digit to settle, and decodes the segment pattern back to BCD.
- Once all four digit positions are captured, converts the frame to binary and pulses valid.
- Used as an on-board display monitor/self-check and as the bench scoreboard front-end for the display path.

Parameters:
SETTLE_CYCLES, 4, consecutive unchanged cycles of {anode,cathodes} required before a capture (range 1..255).

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
anode  input  8  digit enables, active-low; bits [3:0] = ones, tens, hundreds, thousands; bits [7:4] ignored
cathodes  input  8  segments, active-low; [0]=a … [6]=g, [7]=dp (dp ignored)
ones  output  4  captured ones digit (BCD)
tens  output  4  captured tens digit (BCD)
hundreds  output  4  captured hundreds digit (BCD)
thousands  output  4  captured thousands digit (BCD)
value  output  14  binary value of the frame, 0..9999
valid  output  1  one-cycle pulse; digit outputs and value updated in the same cycle
seg_err  output  1  one-cycle pulse on a rejected capture

Behaviour:
- Reset (reset==0 at clk edge): all outputs 0; capture mask 0; stability counter 0; input register 8'hFF/8'hFF; FSM to COLLECT. Takes priority over everything, including mid-CONV; no valid is emitted for the aborted frame.
- Input stage: {anode,cathodes} registered once (s_an, s_cat); all decisions use the registered copy.
- Stability counter:
  - Cleared when s_an/s_cat differ from the previous cycle's values; otherwise increments, saturating at SETTLE_CYCLES.
  - A capture event fires exactly once per stable window, in the cycle the counter reaches SETTLE_CYCLES.
- Capture event classification:
  - s_an[3:0]==4'hF: idle; no action, no error.
  - More than one of s_an[3:0] low: seg_err pulse; nothing stored.
  - Exactly one low: decode s_cat[6:0] (g..a, active-low).
    - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 (hex, 7-bit).
    - 7'h7F (blank) decodes as 0.
    - Any other pattern: seg_err pulse; digit not stored; mask bit unchanged.
  - A valid decode writes the digit register for that position and sets its mask bit. A repeat capture of the same position before frame completion overwrites it.
- FSM:
  - COLLECT:
    - When the mask reaches 4'hF, snapshot the four digits into the conversion register, clear the mask, acc=0, step=0, go to CONV.
    - The snapshot happens in the cycle after the completing capture.
  - CONV: 4 cycles, one per digit from thousands to ones: acc = acc*10 + digit. The *10 is implemented as (acc<<3)+(acc<<1). acc is 14 bits; max 9999, no overflow. After step 3, go to DONE.
  - DONE: register ones/tens/hundreds/thousands from the snapshot, value=acc, valid=1 for this cycle only; go to COLLECT.
- Captures keep running during CONV/DONE into the digit registers and mask; the next frame collects concurrently and does not disturb the snapshot.
  - If the mask fills again before returning to COLLECT, the transition happens on the first COLLECT cycle.
- Latency: completing capture → valid = 6 cycles (1 snapshot + 4 CONV + 1 DONE).
- Outputs hold their values between valid pulses.
- seg_err and valid may assert in the same cycle.

Test Plan:
- Release reset, scan anode F7/FB/FD/FE with cathodes C0/A4/92/92, each held 8 cycles → valid pulses once: thousands=0, hundreds=2, tens=5, ones=5, value=14'd255, exactly 6 cycles after the ones capture.
- Scan 9,9,9,9 (cathodes 90, dp bit toggled randomly) → value=14'd9999 (14'h270F), no seg_err.
- Tens digit held only SETTLE_CYCLES-1 cycles, then anode=FF for 8 cycles, then a full scan → glitch ignored; exactly one valid, with the full-scan digits.
- anode=FC stable 8 cycles → one seg_err pulse, mask unchanged. Cathodes=AA on the hundreds position → one seg_err, no valid until hundreds is re-captured with a legal code.
- reset driven low 2 cycles into CONV of a 1234 frame → no valid, all outputs 0. Next full scan of 4321 → value=14'd4321.
- Back-to-back scans 0255 then 1000 with no gaps → two valid pulses, values 255 then 1000; second frame not corrupted by collection during CONV.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits and a binary value from a scanned 4-digit active-low 7-segment bus.
// A digit is captured after {anode,cathodes} is stable for SETTLE_CYCLES; valid follows the completing capture by 6 cycles.
module seg7_scan_decoder #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  anode,
    input  logic [7:0]  cathodes,
    output logic [3:0]  ones,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic [3:0]  thousands,
    output logic [13:0] value,
    output logic        valid,
    output logic        seg_err
);
    typedef enum logic [1:0] {COLLECT, CONV, DONE} state_t;
    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

    state_t      state, state_next;
    logic [7:0]  s_an, s_cat, p_an, p_cat, cnt;
    logic [3:0]  dig  [4];
    logic [3:0]  snap [4];
    logic [3:0]  mask, sel, dec_dig, conv_dig;
    logic [13:0] acc;
    logic [1:0]  step;
    logic        same, cap, one_hot, multi, dec_ok, cap_store, cap_err, snap_en;

    assign same    = ({s_an, s_cat} == {p_an, p_cat});
    assign cap     = same && (cnt == SETTLE - 8'd1);
    assign sel     = ~s_an[3:0];
    assign one_hot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    assign multi   = (sel != 4'd0) && !one_hot;

    always_comb begin
        dec_ok  = 1'b1;
        dec_dig = 4'd0;
        case (s_cat[6:0])
            7'h40:   dec_dig = 4'd0;
            7'h79:   dec_dig = 4'd1;
            7'h24:   dec_dig = 4'd2;
            7'h30:   dec_dig = 4'd3;
            7'h19:   dec_dig = 4'd4;
            7'h12:   dec_dig = 4'd5;
            7'h02:   dec_dig = 4'd6;
            7'h78:   dec_dig = 4'd7;
            7'h00:   dec_dig = 4'd8;
            7'h10:   dec_dig = 4'd9;
            7'h7F:   dec_dig = 4'd0;
            default: dec_ok  = 1'b0;
        endcase
    end

    assign cap_store = cap && one_hot && dec_ok;
    assign cap_err   = cap && (multi || (one_hot && !dec_ok));
    // step 0 converts thousands (index 3), step 3 converts ones (index 0)
    assign conv_dig  = snap[~step];

    always_comb begin
        state_next = state;
        snap_en    = 1'b0;
        case (state)
            COLLECT: if (mask == 4'hF) begin
                snap_en    = 1'b1;
                state_next = CONV;
            end
            CONV:    if (step == 2'd3) state_next = DONE;
            DONE:    state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= COLLECT;
            s_an      <= 8'hFF;
            s_cat     <= 8'hFF;
            p_an      <= 8'hFF;
            p_cat     <= 8'hFF;
            cnt       <= 8'd0;
            mask      <= 4'd0;
            acc       <= 14'd0;
            step      <= 2'd0;
            ones      <= 4'd0;
            tens      <= 4'd0;
            hundreds  <= 4'd0;
            thousands <= 4'd0;
            value     <= 14'd0;
            valid     <= 1'b0;
            seg_err   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                dig[i]  <= 4'd0;
                snap[i] <= 4'd0;
            end
        end else begin
            s_an    <= anode;
            s_cat   <= cathodes;
            p_an    <= s_an;
            p_cat   <= s_cat;
            state   <= state_next;
            valid   <= 1'b0;
            seg_err <= cap_err;

            if (!same)
                cnt <= 8'd0;
            else if (cnt < SETTLE)
                cnt <= cnt + 8'd1;

            // a capture landing on the snapshot cycle belongs to the next frame
            mask <= (snap_en ? 4'd0 : mask) | (cap_store ? sel : 4'd0);
            for (int i = 0; i < 4; i++)
                if (cap_store && sel[i]) dig[i] <= dec_dig;

            if (snap_en) begin
                for (int i = 0; i < 4; i++) snap[i] <= dig[i];
                acc  <= 14'd0;
                step <= 2'd0;
            end

            if (state == CONV) begin
                acc  <= (acc << 3) + (acc << 1) + {10'd0, conv_dig};
                step <= step + 2'd1;
            end

            if (state == DONE) begin
                ones      <= snap[0];
                tens      <= snap[1];
                hundreds  <= snap[2];
                thousands <= snap[3];
                value     <= acc;
                valid     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed scans against a cycle-level behavioural model of the display monitor, plus literal spot checks.
module tb_seg7_scan_decoder;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  anode, cathodes;
    logic [3:0]  ones, tens, hundreds, thousands;
    logic [13:0] value;
    logic        valid, seg_err;

    seg7_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(rst_n), .anode(anode), .cathodes(cathodes),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .value(value), .valid(valid), .seg_err(seg_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // digit glyphs with dp off (bit7 = 1)
    logic [7:0] glyph [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    logic [15:0] prev_in = 16'hFFFF;
    int          run = 1;
    int          m_dig [4];
    int          m_snap [4];
    logic [3:0]  m_mask;
    int          done_at = -1, collect_at = 0;
    logic        e_valid = 1'b0, e_err = 1'b0;
    int          e_dig [4] = '{0, 0, 0, 0};
    int          e_value = 0;

    function automatic int decode(input logic [6:0] p);
        if (p == 7'h7F) return 0;
        for (int k = 0; k < 10; k++)
            if (glyph[k][6:0] == p) return k;
        return -1;
    endfunction

    always @(posedge clk) begin
        int lows, pos, d;
        cyc++;
        if (!rst_n) begin
            prev_in = 16'hFFFF;
            run = 1;
            m_mask = 4'd0;
            done_at = -1;
            collect_at = 0;
            e_valid = 1'b0;
            e_err = 1'b0;
            e_value = 0;
            for (int i = 0; i < 4; i++) begin
                m_dig[i] = 0; m_snap[i] = 0; e_dig[i] = 0;
            end
        end else begin
            e_valid = 1'b0;
            e_err = 1'b0;
            if (cyc >= collect_at && m_mask == 4'hF) begin
                for (int i = 0; i < 4; i++) m_snap[i] = m_dig[i];
                m_mask = 4'd0;
                done_at = cyc + 5;
                collect_at = cyc + 6;
            end
            if (run == SETTLE + 1) begin
                lows = 0; pos = 0;
                for (int i = 0; i < 4; i++)
                    if (!prev_in[8+i]) begin lows++; pos = i; end
                if (lows > 1) e_err = 1'b1;
                else if (lows == 1) begin
                    d = decode(prev_in[6:0]);
                    if (d < 0) e_err = 1'b1;
                    else begin m_dig[pos] = d; m_mask[pos] = 1'b1; end
                end
            end
            if (cyc == done_at) begin
                e_valid = 1'b1;
                for (int i = 0; i < 4; i++) e_dig[i] = m_snap[i];
                e_value = m_snap[3]*1000 + m_snap[2]*100 + m_snap[1]*10 + m_snap[0];
            end
            if ({anode, cathodes} == prev_in) run++;
            else begin run = 1; prev_in = {anode, cathodes}; end
        end
    end

    // ---------------- per-cycle compare and pulse log ----------------
    int n_valid = 0, n_err = 0, val_cyc = 0;
    int vq [$];

    always @(negedge clk) begin
        logic [31:0] act, exp_v;
        if (cyc > 0) begin
            act   = {valid, seg_err, thousands, hundreds, tens, ones, value};
            exp_v = {e_valid, e_err, 4'(e_dig[3]), 4'(e_dig[2]), 4'(e_dig[1]), 4'(e_dig[0]), 14'(e_value)};
            total++;
            if (act !== exp_v) begin
                bad++;
                $display("FAIL cycle_%0d: got %h expected %h", cyc, act, exp_v);
            end
        end
        if (valid === 1'b1) begin
            n_valid++;
            val_cyc = cyc;
            vq.push_back(int'(value));
        end
        if (seg_err === 1'b1) n_err++;
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic hold(input logic [7:0] a, input logic [7:0] c, input int n);
        anode = a;
        cathodes = c;
        repeat (n) @(negedge clk);
    endtask

    int t_ones;

    task automatic scan(input int d3, input int d2, input int d1, input int d0,
                        input int n, input bit rand_dp);
        logic [7:0] m;
        m = rand_dp ? 8'($urandom_range(0, 1)) << 7 : 8'h80;
        hold(8'hF7, glyph[d3] & (8'h7F | m), n);
        m = rand_dp ? 8'($urandom_range(0, 1)) << 7 : 8'h80;
        hold(8'hFB, glyph[d2] & (8'h7F | m), n);
        m = rand_dp ? 8'($urandom_range(0, 1)) << 7 : 8'h80;
        hold(8'hFD, glyph[d1] & (8'h7F | m), n);
        m = rand_dp ? 8'($urandom_range(0, 1)) << 7 : 8'h80;
        t_ones = cyc;
        hold(8'hFE, glyph[d0] & (8'h7F | m), n);
    endtask

    int v0, r0;

    initial begin
        rst_n = 1'b0;
        anode = 8'hFF;
        cathodes = 8'hFF;
        repeat (3) @(negedge clk);
        chk("reset_value", int'(value), 0);
        chk("reset_valid", int'(valid), 0);
        rst_n = 1'b1;
        hold(8'hFF, 8'hFF, 4);

        // 0255 with literal latency
        v0 = n_valid;
        scan(0, 2, 5, 5, 8, 1'b0);
        hold(8'hFF, 8'hFF, 10);
        chk("t1_pulses", n_valid - v0, 1);
        chk("t1_value", vq[$], 255);
        chk("t1_digits", int'({thousands, hundreds, tens, ones}), 16'h0255);
        chk("t1_latency", val_cyc - t_ones, 12);

        // 9999 with dp noise
        r0 = n_err;
        scan(9, 9, 9, 9, 8, 1'b1);
        hold(8'hFF, 8'hFF, 10);
        chk("t2_value", int'(value), 9999);
        chk("t2_no_err", n_err - r0, 0);

        // short tens glitch is ignored
        v0 = n_valid;
        hold(8'hFD, 8'hC0, SETTLE - 1);
        hold(8'hFF, 8'hFF, 8);
        scan(8, 0, 1, 6, 8, 1'b0);
        hold(8'hFF, 8'hFF, 10);
        chk("t3_pulses", n_valid - v0, 1);
        chk("t3_value", int'(value), 8016);

        // two anodes low, then an illegal glyph on hundreds
        v0 = n_valid; r0 = n_err;
        hold(8'hFC, 8'hC0, 8);
        hold(8'hFF, 8'hFF, 4);
        chk("t4_multi_err", n_err - r0, 1);
        hold(8'hF7, glyph[1], 8);
        hold(8'hFB, 8'hAA, 8);
        hold(8'hFD, glyph[0], 8);
        hold(8'hFE, glyph[3], 8);
        hold(8'hFF, 8'hFF, 10);
        chk("t4_errs", n_err - r0, 2);
        chk("t4_no_valid", n_valid - v0, 0);
        hold(8'hFB, glyph[6], 8);
        hold(8'hFF, 8'hFF, 10);
        chk("t4_valid", n_valid - v0, 1);
        chk("t4_value", int'(value), 1603);

        // reset in the middle of conversion
        v0 = n_valid;
        scan(1, 2, 3, 4, 8, 1'b0);
        hold(8'hFF, 8'hFF, 1);
        rst_n = 1'b0;
        hold(8'hFF, 8'hFF, 2);
        rst_n = 1'b1;
        hold(8'hFF, 8'hFF, 12);
        chk("t5_aborted", n_valid - v0, 0);
        chk("t5_value", int'(value), 0);
        chk("t5_digits", int'({thousands, hundreds, tens, ones}), 0);
        scan(4, 3, 2, 1, 8, 1'b0);
        hold(8'hFF, 8'hFF, 10);
        chk("t5_after", int'(value), 4321);

        // back-to-back frames with minimal holds
        v0 = n_valid;
        scan(0, 2, 5, 5, SETTLE + 2, 1'b0);
        scan(1, 0, 0, 0, SETTLE + 2, 1'b0);
        hold(8'hFF, 8'hFF, 12);
        chk("t6_pulses", n_valid - v0, 2);
        chk("t6_first", vq[vq.size()-2], 255);
        chk("t6_second", vq[vq.size()-1], 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
